// File: rtl/fake_n64_ctrl.sv
// Passive joybus receiver: low-run width decodes to a bit, strobed on derived_clk, first 8 bits form cmd_byte.
// Latency 3 sample_clk edges from line rise to derived_signal; no backpressure, the line is only observed.
module fake_n64_ctrl #(
    parameter int LOW_ONE_MAX  = 3,
    parameter int LOW_MAX      = 12,
    parameter int IDLE_SAMPLES = 8,
    parameter int CNT_W        = 5
) (
    input  logic       sample_clk,
    input  logic       reset_n,
    input  logic       data,
    output logic       derived_signal,
    output logic       derived_clk,
    output logic [7:0] cmd_byte,
    output logic       cmd_valid
);
    localparam logic [CNT_W-1:0] ONE_MAX_C = CNT_W'(LOW_ONE_MAX);
    localparam logic [CNT_W-1:0] LOW_MAX_C = CNT_W'(LOW_MAX);
    localparam logic [CNT_W-1:0] IDLE_C    = CNT_W'(IDLE_SAMPLES);
    localparam logic [CNT_W-1:0] SAT_C     = '1;

    logic             sync1_q, sync2_q, dp_q;
    logic [CNT_W-1:0] low_q, low_d, high_q, high_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic [7:0]       shift_q, shift_d, cmd_q, cmd_d;
    logic             strb_q, strb_d, dclk_q, dclk_d;
    logic             dsig_q, dsig_d, vld_q, vld_d;
    logic             fall, rise, emit, rx_bit;

    assign fall   = dp_q & ~sync2_q;
    assign rise   = ~dp_q & sync2_q;
    assign emit   = rise && (low_q <= LOW_MAX_C);
    assign rx_bit = (low_q <= ONE_MAX_C);

    always_comb begin
        low_d   = low_q;
        high_d  = high_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        cmd_d   = cmd_q;
        dsig_d  = dsig_q;
        vld_d   = 1'b0;
        dclk_d  = strb_q;
        strb_d  = 1'b0;

        // The fall sample itself is the first low sample of the run.
        if (fall) begin
            low_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (!sync2_q && low_q != SAT_C) begin
            low_d = low_q + 1'b1;
        end

        if (fall) begin
            high_d = '0;
        end else if (sync2_q && high_q != SAT_C) begin
            high_d = high_q + 1'b1;
        end

        if (rise && !emit) begin
            bcnt_d  = '0;
            shift_d = '0;
        end else if (emit) begin
            dsig_d  = rx_bit;
            dclk_d  = 1'b1;
            strb_d  = 1'b1;
            shift_d = {shift_q[6:0], rx_bit};
            if (bcnt_q != 4'hF) begin
                bcnt_d = bcnt_q + 1'b1;
            end
            if (bcnt_q == 4'd7) begin
                cmd_d = {shift_q[6:0], rx_bit};
                vld_d = 1'b1;
            end
        end

        // A long enough high run ends the frame; never coincides with a rise.
        if (high_q == IDLE_C) begin
            bcnt_d  = '0;
            shift_d = '0;
        end
    end

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dp_q    <= 1'b1;
            low_q   <= '0;
            high_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            cmd_q   <= '0;
            strb_q  <= 1'b0;
            dclk_q  <= 1'b0;
            dsig_q  <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            sync1_q <= data;
            sync2_q <= sync1_q;
            dp_q    <= sync2_q;
            low_q   <= low_d;
            high_q  <= high_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            cmd_q   <= cmd_d;
            strb_q  <= strb_d;
            dclk_q  <= dclk_d;
            dsig_q  <= dsig_d;
            vld_q   <= vld_d;
        end
    end

    assign derived_signal = dsig_q;
    assign derived_clk    = dclk_q;
    assign cmd_byte       = cmd_q;
    assign cmd_valid      = vld_q;
endmodule

// File: tb/tb_fake_n64_ctrl.sv
// Scoreboard bench: stimulus is a list of low/high run lengths, the model turns each run into an expected bit.
module tb_fake_n64_ctrl;
    localparam int LOW_ONE_MAX  = 3;
    localparam int LOW_MAX      = 12;
    localparam int IDLE_SAMPLES = 8;

    logic       sample_clk = 1'b0;
    logic       reset_n    = 1'b0;
    logic       data       = 1'b1;
    logic       derived_signal, derived_clk, cmd_valid;
    logic [7:0] cmd_byte;

    fake_n64_ctrl dut (
        .sample_clk    (sample_clk),
        .reset_n       (reset_n),
        .data          (data),
        .derived_signal(derived_signal),
        .derived_clk   (derived_clk),
        .cmd_byte      (cmd_byte),
        .cmd_valid     (cmd_valid)
    );

    always #5 sample_clk = ~sample_clk;

    int cyc = 0;
    always @(posedge sample_clk) cyc <= cyc + 1;

    typedef struct {
        logic       b;
        int         at;
        logic       v;
        logic [7:0] cmd;
    } exp_t;
    exp_t q[$];

    int         checks = 0;
    int         errors = 0;
    int         nbits = 0;
    logic [7:0] acc = 8'h00;
    logic [7:0] last_cmd = 8'h00;
    int         exp_pulses = 0;
    int         seen_pulses = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: a low run of lo samples ending at cycle 'at' yields bit 1, bit 0 or a frame abort.
    task automatic model_rise(input int lo, input int at);
        logic bv;
        if (lo > LOW_MAX) begin
            nbits = 0;
            acc   = 8'h00;
        end else begin
            bv    = (lo <= LOW_ONE_MAX);
            acc   = {acc[6:0], bv};
            nbits = nbits + 1;
            if (nbits == 8) begin
                last_cmd = acc;
                exp_pulses++;
            end
            q.push_back('{b: bv, at: at + 3, v: (nbits == 8), cmd: last_cmd});
        end
    endtask

    // Called at a negedge; leaves the line low lo cycles then high hi cycles.
    task automatic send_run(input int lo, input int hi);
        data = 1'b0;
        repeat (lo) @(negedge sample_clk);
        data = 1'b1;
        model_rise(lo, cyc);
        repeat (hi) @(negedge sample_clk);
        if (hi >= IDLE_SAMPLES) begin
            nbits = 0;
            acc   = 8'h00;
        end
    endtask

    task automatic send_bit(input logic b, input bit jitter);
        int lo;
        if (b) lo = jitter ? $urandom_range(2, 3) : 2;
        else   lo = jitter ? $urandom_range(5, 7) : 6;
        send_run(lo, b ? (jitter ? $urandom_range(5, 6) : 6) : (jitter ? $urandom_range(2, 3) : 2));
    endtask

    task automatic send_frame(input logic [7:0] byte_v, input bit jitter, input int idle);
        for (int i = 7; i >= 0; i--) send_bit(byte_v[i], jitter);
        send_run(2, idle);
    endtask

    // Monitor: pops an expectation on every derived_clk rising edge, checks widths and stray pulses.
    initial begin
        logic prev_clk;
        int   hi_cnt;
        exp_t e;
        prev_clk = 1'b0;
        hi_cnt   = 0;
        forever begin
            @(negedge sample_clk);
            if (!reset_n) begin
                prev_clk = 1'b0;
                hi_cnt   = 0;
            end else begin
                if (cmd_valid) seen_pulses++;
                if (derived_clk && !prev_clk) begin
                    if (q.size() == 0) begin
                        chk("unexpected_strobe", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("derived_signal", derived_signal, e.b);
                        chk("strobe_cycle", cyc, e.at);
                        chk("cmd_valid_at_strobe", cmd_valid, e.v);
                        chk("cmd_byte_at_strobe", cmd_byte, e.cmd);
                    end
                end else begin
                    chk("stray_cmd_valid", cmd_valid, 0);
                end
                if (derived_clk) begin
                    hi_cnt++;
                end else if (prev_clk) begin
                    chk("strobe_width", hi_cnt, 2);
                    hi_cnt = 0;
                end
                prev_clk = derived_clk;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_derived_signal"}, derived_signal, 1);
        chk({tag, "_derived_clk"}, derived_clk, 0);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_byte"}, cmd_byte, 0);
    endtask

    task automatic mid_frame_reset();
        int n;
        data = 1'b0;
        n = 0;
        repeat (4) @(negedge sample_clk);
        while (q.size() != 0 && n < 40) begin
            @(negedge sample_clk);
            n++;
        end
        chk("drain_before_reset", q.size(), 0);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        data     = 1'b1;
        nbits    = 0;
        acc      = 8'h00;
        last_cmd = 8'h00;
        q.delete();
        repeat (3) @(negedge sample_clk);
        reset_n = 1'b1;
        repeat (12) @(negedge sample_clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n = 1'b0;
        data    = 1'b1;
        repeat (3) @(negedge sample_clk);
        check_reset_outputs("in_reset");
        reset_n = 1'b1;
        repeat (100) @(negedge sample_clk);
        check_reset_outputs("idle");

        // Single 3 us low then high
        send_run(6, 20);
        chk("single_zero", derived_signal, 0);

        // Command 0x01 plus stop bit
        send_frame(8'h01, 1'b0, 12);
        chk("cmd_01", cmd_byte, 8'h01);

        // Back-to-back frames separated by 6 us idle
        send_frame(8'h00, 1'b0, 12);
        chk("cmd_00", cmd_byte, 8'h00);
        send_frame(8'hFF, 1'b0, 12);
        chk("cmd_ff", cmd_byte, 8'hFF);

        // Boundary low runs, then abort, then a frame starting from a cleared count
        send_run(3, 4);
        send_run(4, 4);
        send_run(12, 4);
        send_run(13, 4);
        send_frame(8'hA5, 1'b0, 12);
        chk("cmd_after_abort", cmd_byte, 8'hA5);

        // High runs of 7 keep the frame, 8 ends it
        send_run(6, 2);
        send_run(2, 7);
        send_run(6, 2);
        for (int i = 0; i < 5; i++) send_run(2, 6);
        send_run(6, 8);
        for (int i = 0; i < 8; i++) send_run(6, 2);
        send_run(2, 12);
        chk("cmd_idle_boundary", cmd_byte, 8'h00);

        // Line held low for a long time
        send_run(60, 20);
        chk("long_low_hold", cmd_byte, 8'h00);

        // Console polling replay with reset mid-byte
        send_frame(8'h01, 1'b1, 14);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        mid_frame_reset();
        chk("post_reset_cmd", cmd_byte, 8'h00);
        for (int i = 0; i < 3; i++) send_frame(8'h01, 1'b1, $urandom_range(12, 20));
        chk("replay_cmd", cmd_byte, 8'h01);

        // Randomized frames with occasional aborting lows
        for (int i = 0; i < 24; i++) begin
            n = $urandom_range(0, 3);
            if (n == 0) send_run($urandom_range(13, 25), $urandom_range(2, 6));
            if (n == 1) begin
                for (int k = 0; k < $urandom_range(1, 6); k++) send_bit(1'($urandom_range(0, 1)), 1'b1);
                send_run($urandom_range(13, 25), $urandom_range(2, 6));
            end
            send_frame(8'($urandom_range(0, 255)), 1'b1, $urandom_range(12, 20));
            for (int k = 0; k < $urandom_range(0, 3); k++) send_bit(1'($urandom_range(0, 1)), 1'b1);
            send_run(2, $urandom_range(12, 20));
        end

        repeat (20) @(negedge sample_clk);
        chk("queue_drained", q.size(), 0);
        chk("cmd_valid_pulses", seen_pulses, exp_pulses);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
